// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Desc     : MEM-stage load/store initiator. Drives a word-wide, big-endian
//            data memory, sign/zero-extends loads and performs sub-word
//            stores as read-modify-write. Stalls the pipeline per operation.
//            Optional macro LSU_ALIGN_CHECK_EN enables misalignment faults.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]  r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;     // only the sub-word part is needed after accept
  logic [31:0] r_rdata;
  logic        r_fault;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_wdata;
  logic        r_mem_write;
  logic        r_mem_read;

  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Halfword lane: upper half at offset 0, lower half at offset 2 (big-endian)
  assign w_half = r_off[1] ? mem_readData[15:0] : mem_readData[31:16];

  // Select the addressed byte lane, offset 0 being the most significant byte
  always_comb begin
    w_byte = 8'h00;
    case (r_off)
      2'd0: w_byte = mem_readData[31:24];
      2'd1: w_byte = mem_readData[23:16];
      2'd2: w_byte = mem_readData[15:8];
      2'd3: w_byte = mem_readData[7:0];
    endcase
  end

  // Extend the extracted lane to the 32-bit load result
  always_comb begin
    w_load = mem_readData;
    if (r_size == 2'b00) begin
      w_load = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (r_size == 2'b01) begin
      w_load = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
    end
  end

  // Merge store data into the word read back for sub-word stores
  always_comb begin
    w_merged = mem_readData;
    if (r_size == 2'b00) begin
      case (r_off)
        2'd0: w_merged[31:24] = r_wdata[7:0];
        2'd1: w_merged[23:16] = r_wdata[7:0];
        2'd2: w_merged[15:8]  = r_wdata[7:0];
        2'd3: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_size == 2'b01) begin
      if (r_off[1]) w_merged[15:0]  = r_wdata;
      else          w_merged[31:16] = r_wdata;
    end
  end

  // Operation sequencer: latch request, issue strobes, produce response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_write       <= 1'b0;
      r_size        <= 2'b00;
      r_unsigned    <= 1'b0;
      r_off         <= 2'b00;
      r_wdata       <= 16'h0000;
      r_rdata       <= 32'h0;
      r_fault       <= 1'b0;
      r_mem_address <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write       <= req_write;
            r_size        <= req_size;
            r_unsigned    <= req_unsigned;
            r_off         <= req_addr[1:0];
            r_wdata       <= req_wdata[15:0];
            r_mem_address <= {req_addr[31:2], 2'b00};
            if (w_misalign) begin
              r_state <= S_DONE;
              r_fault <= 1'b1;
              r_rdata <= 32'h0;
            end else if (req_write && req_size[1]) begin
              // Full-word store needs no read-back
              r_state     <= S_WR_ISSUE;
              r_mem_write <= 1'b1;
              r_mem_wdata <= req_wdata;
            end else begin
              r_state    <= S_RD_ISSUE;
              r_mem_read <= 1'b1;
            end
          end
        end
        S_RD_ISSUE: begin
          r_mem_read <= 1'b0;
          r_state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_write) begin
            r_state     <= S_WR_ISSUE;
            r_mem_write <= 1'b1;
            r_mem_wdata <= w_merged;
          end else begin
            r_state <= S_DONE;
            r_rdata <= w_load;
            r_fault <= 1'b0;
          end
        end
        S_WR_ISSUE: begin
          r_mem_write <= 1'b0;
          r_fault     <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall = ~reset & (((r_state == S_IDLE) & req_valid) |
                           ((r_state != S_IDLE) & (r_state != S_DONE)));
  assign resp_valid    = (r_state == S_DONE);
  assign resp_rdata    = r_rdata;
  assign fault         = r_fault;
  assign mem_address   = r_mem_address;
  assign mem_writeData = r_mem_wdata;
  assign mem_memWrite  = r_mem_write;
  assign mem_memRead   = r_mem_read;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Desc     : Scoreboard bench for mem_access_unit with a byte-array reference
//            model of the big-endian data memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, fault, mem_memWrite, mem_memRead;
  logic [31:0] resp_rdata, mem_address, mem_writeData, mem_readData;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .fault(fault), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_memWrite(mem_memWrite),
    .mem_memRead(mem_memRead), .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory attached to the DUT (synchronous read and write)
  logic [31:0] dmem [64];
  always @(posedge clk) begin
    if (mem_memWrite) dmem[mem_address[7:2]] <= mem_writeData;
    if (mem_memRead)  mem_readData <= dmem[mem_address[7:2]];
  end

  // Reference model: plain byte array, big-endian
  logic [7:0] ref_mem [256];

  typedef struct {
    logic [31:0] rdata;
    bit          flt;
    bit          chk_data;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  bit   busy = 1'b0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = (a % 256) / 4 * 4;
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  function automatic void ref_access(input bit w, input logic [1:0] sz, input bit u,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output bit flt,
                                     output int lat, output int nrd, output int nwr);
    int n, base;
    logic [31:0] v, ext;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a[7:0]) / n * n;
    flt  = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    flt = (int'(a[7:0]) % n) != 0;
`endif
    rd = 32'h0;
    if (flt) begin
      lat = 1; nrd = 0; nwr = 0;
      return;
    end
    if (!w) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, ref_mem[base+i]};
      if (!u && n < 4 && v[8*n-1]) begin
        ext = 32'hFFFFFFFF;
        v   = v | (ext << (8*n));
      end
      rd = v; lat = 3; nrd = 1; nwr = 0;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[base+i] = 8'(wd >> (8*(n-1-i)));
      lat = (n == 4) ? 2 : 4;
      nrd = (n == 4) ? 0 : 1;
      nwr = 1;
    end
  endfunction

  // Monitor: pops the scoreboard on every response and watches the strobes
  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      checks++;
      if (mem_memRead && mem_memWrite) begin
        errors++;
        $display("FAIL both_strobes: read=%b write=%b required not both high", mem_memRead, mem_memWrite);
      end
      if (mem_memRead)  rd_cnt++;
      if (mem_memWrite) wr_cnt++;
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: resp_valid=1 required 0 (no operation pending)");
        end else begin
          me = sbq.pop_front();
          chk("resp_cycle", 32'(cyc - me.acc), 32'(me.lat));
          if (me.chk_data) chk("resp_rdata", resp_rdata, me.rdata);
          chk("fault", 32'(fault), 32'(me.flt));
          chk("read_strobes", 32'(rd_cnt), 32'(me.nrd));
          chk("write_strobes", 32'(wr_cnt), 32'(me.nwr));
          chk("stall_at_resp", 32'(stall), 32'h0);
        end
        rd_cnt = 0;
        wr_cnt = 0;
        busy   = 1'b0;
      end else if (busy) begin
        chk("stall_busy", 32'(stall), 32'h1);
      end else if (!req_valid) begin
        chk("stall_idle", 32'(stall), 32'h0);
      end
    end
  end

  // Present one request at the current cycle (called at posedge+1)
  task automatic present(input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit use_exp, input logic [31:0] exp_d, input bit push);
    exp_t e;
    logic [31:0] md;
    bit mf;
    int lat, nrd, nwr;
    if (push) begin
      ref_access(w, sz, u, a, wd, md, mf, lat, nrd, nwr);
      e.rdata    = use_exp ? exp_d : md;
      e.flt      = mf;
      e.chk_data = !w || mf;
      e.lat      = lat;
      e.nrd      = nrd;
      e.nwr      = nwr;
      e.acc      = cyc;
      sbq.push_back(e);
    end
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    busy      = 1'b1;
  endtask

  // Full operation: present, scramble inputs while busy, wait for completion
  task automatic op(input bit w, input logic [1:0] sz, input bit u,
                    input logic [31:0] a, input logic [31:0] wd,
                    input bit use_exp, input logic [31:0] exp_d);
    int n;
    present(w, sz, u, a, wd, use_exp, exp_d, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'(($urandom_range(0, 1)));
    req_write = 1'($urandom_range(0, 1));
    req_size  = 2'($urandom_range(0, 3));
    req_addr  = $urandom;
    req_wdata = $urandom;
    n = 0;
    while (busy && n < 12) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", n);
      busy = 1'b0;
      sbq.delete();
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    {ref_mem[16], ref_mem[17], ref_mem[18], ref_mem[19]} = 32'h11223344;
    {ref_mem[32], ref_mem[33], ref_mem[34], ref_mem[35]} = 32'h80FF7F01;
    for (int i = 0; i < 64; i++) dmem[i] = ref_word(i * 4);
    mem_readData = 32'h0;

    // Reset values, with a request present to check stall gating
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_mem_read", 32'(mem_memRead), 32'h0);
    chk("rst_mem_write", 32'(mem_memWrite), 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_writeData, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    req_valid = 1'b0;
    reset = 1'b0;
    idle(2);

    // Word load and sub-word loads
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11223344);
    op(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b1, 32'hFFFFFFFF);
    op(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b1, 32'h000000FF);
    op(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b1, 32'hFFFF80FF);
    op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b1, 32'h00007F01);

    // Byte store then read back
    op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 1'b0, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11AB3344);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0);

    // Misaligned halfword store
    op(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF, 1'b0, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11223344);
`else
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1122BEEF);
`endif
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0);
    idle(1);

    // Reset during RD_WAIT of a byte store: nothing may be written
    present(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000EE, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_stall", 32'(stall), 32'h1);
    reset = 1'b1; req_valid = 1'b0; busy = 1'b0;
    #1;
    chk("mid_reset_stall", 32'(stall), 32'h0);
    chk("mid_reset_read", 32'(mem_memRead), 32'h0);
    chk("mid_reset_write", 32'(mem_memWrite), 32'h0);
    chk("mid_reset_resp", 32'(resp_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11223344);

    // Reset while the write strobe of a word store is high
    present(1'b1, 2'b10, 1'b0, 32'h18, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("wr_issue_strobe", 32'(mem_memWrite), 32'h1);
    reset = 1'b1; req_valid = 1'b0; busy = 1'b0;
    #1;
    chk("async_write_drop", 32'(mem_memWrite), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    op(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 1'b1, ref_word(32'h18));

    // Back-to-back load then word store
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11223344);
    op(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, 1'b0, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 32'hCAFEF00D);

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         32'($urandom_range(0, 255)), $urandom, 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: %0d left, required 0", sbq.size());
    end
    for (int i = 0; i < 64; i++) chk("mem_word", dmem[i], ref_word(i * 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
